// File: rtl/dm_pkg.sv
// Shared debug-module types: DTM op codes, DMI status codes and DMI request/response records.
package dm;

   localparam int unsigned DefaultAddrWidth = 7;
   localparam int unsigned DmiWidth = DefaultAddrWidth + 34;

   typedef enum logic [1:0] {
      DtmNop   = 2'd0,
      DtmRead  = 2'd1,
      DtmWrite = 2'd2
   } dtm_op_e;

   localparam logic [1:0] DmiSuccess = 2'd0;
   localparam logic [1:0] DmiFailed  = 2'd2;
   localparam logic [1:0] DmiBusy    = 2'd3;

   typedef struct packed {
      logic [DefaultAddrWidth-1:0] addr;
      dtm_op_e                     op;
      logic [31:0]                 data;
   } dmi_req_t;

   typedef struct packed {
      logic [31:0] data;
      logic [1:0]  resp;
   } dmi_resp_t;

   typedef enum logic [2:0] {
      Idle      = 3'd0,
      Read      = 3'd1,
      WaitRead  = 3'd2,
      Write     = 3'd3,
      WaitWrite = 3'd4
   } dmi_state_e;

endpackage

// File: rtl/dmi_jtag_access.sv
// DMIACCESS data register and DMI request sequencer in the TCK domain.
// Owns the 41-bit DR, issues one DMI request per Update-DR and tracks sticky status.
module dmi_jtag_access
   import dm::*;
#(
   parameter int unsigned AddrWidth = 7
) (
   input  logic                 tck_i,
   input  logic                 trst_ni,
   input  logic                 test_logic_reset_i,
   input  logic                 capture_dr_i,
   input  logic                 shift_dr_i,
   input  logic                 update_dr_i,
   input  logic                 dmi_access_i,
   input  logic                 dmi_reset_i,
   input  logic                 dmi_tdi_i,
   output logic                 dmi_tdo_o,
   output logic [1:0]           dmi_error_o,
   output logic                 dmi_req_valid_o,
   input  logic                 dmi_req_ready_i,
   output logic [AddrWidth-1:0] dmi_req_addr_o,
   output logic [1:0]           dmi_req_op_o,
   output logic [31:0]          dmi_req_data_o,
   input  logic                 dmi_resp_valid_i,
   output logic                 dmi_resp_ready_o,
   input  logic [31:0]          dmi_resp_data_i,
   input  logic [1:0]           dmi_resp_resp_i
);

   localparam int unsigned DrWidth = AddrWidth + 34;

   dmi_state_e           state_r, state_next_s;
   logic [DrWidth-1:0]   dr_r, dr_next_s;
   logic [AddrWidth-1:0] addr_r;
   logic [31:0]          data_r;
   logic [1:0]           error_r, error_next_s;
   logic [1:0]           cap_status_s;
   logic                 idle_s, capture_s, shift_s, update_s, update_ok_s;
   logic                 busy_evt_s, fail_evt_s, waiting_s;

   assign idle_s      = (state_r == Idle);
   assign waiting_s   = (state_r == WaitRead) || (state_r == WaitWrite);
   assign capture_s   = capture_dr_i & dmi_access_i;
   assign shift_s     = shift_dr_i & dmi_access_i;
   assign update_s    = update_dr_i & dmi_access_i;
   assign update_ok_s = update_s & idle_s & (error_r == DmiSuccess);
   assign busy_evt_s  = (capture_s | update_s) & ~idle_s;
   assign fail_evt_s  = waiting_s & dmi_resp_valid_i & (dmi_resp_resp_i != 2'd0);
   // A capture while a request is outstanding reports busy unless an earlier error already sticks.
   assign cap_status_s = (!idle_s && error_r == DmiSuccess) ? DmiBusy : error_r;

   assign dmi_tdo_o        = dr_r[0];
   assign dmi_error_o      = error_r;
   assign dmi_resp_ready_o = 1'b1;

   // FSM state register.
   always_ff @(posedge tck_i) begin
      if (!trst_ni) begin
         state_r <= Idle;
      end else if (test_logic_reset_i) begin
         state_r <= Idle;
      end else begin
         state_r <= state_next_s;
      end
   end

   // FSM next-state logic; responses outside the wait states are drained.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         Idle: begin
            if (update_ok_s && dr_r[1:0] == DtmRead) begin
               state_next_s = Read;
            end else if (update_ok_s && dr_r[1:0] == DtmWrite) begin
               state_next_s = Write;
            end else begin
               state_next_s = Idle;
            end
         end
         Read:      state_next_s = dmi_req_ready_i  ? WaitRead  : Read;
         Write:     state_next_s = dmi_req_ready_i  ? WaitWrite : Write;
         WaitRead:  state_next_s = dmi_resp_valid_i ? Idle      : WaitRead;
         WaitWrite: state_next_s = dmi_resp_valid_i ? Idle      : WaitWrite;
         default:   state_next_s = Idle;
      endcase
   end

   // FSM request outputs; payload is held at zero whenever no request is valid.
   always_comb begin
      dmi_req_valid_o = 1'b0;
      dmi_req_addr_o  = '0;
      dmi_req_op_o    = DtmNop;
      dmi_req_data_o  = 32'd0;
      case (state_r)
         Read: begin
            dmi_req_valid_o = 1'b1;
            dmi_req_addr_o  = addr_r;
            dmi_req_op_o    = DtmRead;
         end
         Write: begin
            dmi_req_valid_o = 1'b1;
            dmi_req_addr_o  = addr_r;
            dmi_req_op_o    = DtmWrite;
            dmi_req_data_o  = data_r;
         end
         default: begin
            dmi_req_valid_o = 1'b0;
         end
      endcase
   end

   // Sticky status: clears dominate, then the first error recorded is kept.
   always_comb begin
      error_next_s = error_r;
      if (dmi_reset_i || test_logic_reset_i) begin
         error_next_s = DmiSuccess;
      end else if (error_r != DmiSuccess) begin
         error_next_s = error_r;
      end else if (fail_evt_s) begin
         error_next_s = DmiFailed;
      end else if (busy_evt_s) begin
         error_next_s = DmiBusy;
      end else begin
         error_next_s = error_r;
      end
   end

   // DR capture/shift path.
   always_comb begin
      dr_next_s = dr_r;
      if (test_logic_reset_i) begin
         dr_next_s = '0;
      end else if (capture_s) begin
         dr_next_s = {addr_r, data_r, cap_status_s};
      end else if (shift_s) begin
         dr_next_s = {dmi_tdi_i, dr_r[DrWidth-1:1]};
      end else begin
         dr_next_s = dr_r;
      end
   end

   // Data path registers: DR, address/data latches and status.
   always_ff @(posedge tck_i) begin
      if (!trst_ni) begin
         dr_r    <= '0;
         addr_r  <= '0;
         data_r  <= 32'd0;
         error_r <= DmiSuccess;
      end else begin
         dr_r    <= dr_next_s;
         error_r <= error_next_s;
         if (test_logic_reset_i) begin
            addr_r <= '0;
            data_r <= 32'd0;
         end else if (update_ok_s) begin
            addr_r <= dr_r[DrWidth-1 -: AddrWidth];
            data_r <= dr_r[33:2];
         end else if (state_r == WaitRead && dmi_resp_valid_i) begin
            data_r <= dmi_resp_data_i;
         end
      end
   end

endmodule
